rx_addr_filter: RTL
===================

Name: rx_addr_filter

Overview:
- Sequences the team's 8-bit `comparator` over the header bytes of each received nRF packet and decides whether the packet is addressed to this node.
- Sits between the nRF SPI RX byte stream and the command decoder.
- Drives one external `comparator` instance through its `o_Cmp_*` / `i_Cmp_Equal` ports.
- Forwards payload bytes only for matching packets; all other packets are consumed and discarded.

Parameters:
- ADDR_BYTES, 2, number of header (address) bytes compared per packet; range 1–4.
- PKT_BYTES, 10, total bytes per packet including the header; must be greater than ADDR_BYTES.

Ports:
- i_Clk  input  1  system clock, rising edge.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_Addr  input  8*ADDR_BYTES  node address; sampled only on an accepted i_Start.
- i_Start  input  1  one-cycle pulse marking the start of a new packet.
- i_Byte  input  8  RX data byte.
- i_Byte_Valid  input  1  i_Byte is valid this cycle; there is no backpressure.
- o_Cmp_Data1  output  8  to comparator i_Data1.
- i_Cmp_Equal  input  1  from comparator o_Equal; combinational in the same cycle.
- o_Cmp_Data2  output  8  to comparator i_Data2.
- o_Payload  output  8  forwarded payload byte.
- o_Payload_Valid  output  1  o_Payload is valid; one-cycle pulse per byte.
- o_Match  output  1  one-cycle pulse: header matched.
- o_Drop  output  1  one-cycle pulse: header mismatched.
- o_Done  output  1  one-cycle pulse: last packet byte consumed.
- o_Busy  output  1  high while a packet is in progress.

Behaviour:
- Reset (async, i_Rst_n=0):
  - State = IDLE; byte counter = 0; mismatch flag = 0; address register = 0.
  - All registered outputs (o_Payload, o_Payload_Valid, o_Match, o_Drop, o_Done, o_Busy) are 0.
  - Release is synchronous to i_Clk.
- States: IDLE, HDR, PAY, DISC.
- IDLE:
  - i_Byte_Valid is ignored.
  - On i_Start: latch i_Addr, clear counter and mismatch flag, go to HDR, set o_Busy=1 on the next cycle.
- HDR:
  - Comparator drive (combinational): o_Cmp_Data1 = i_Byte; o_Cmp_Data2 = latched address byte[counter], with byte 0 = MSB byte i_Addr[8*ADDR_BYTES-1 -: 8].
  - In IDLE, PAY and DISC, both o_Cmp_Data1 and o_Cmp_Data2 are 8'h00.
  - On each i_Byte_Valid: increment counter; if i_Cmp_Equal=0, set mismatch flag.
  - On the valid byte where counter = ADDR_BYTES-1, the final decision includes the current comparison:
    - Full match: o_Match pulses on the next cycle, go to PAY.
    - Otherwise: o_Drop pulses on the next cycle, go to DISC.
  - Exactly one of o_Match / o_Drop fires per completed header.
- PAY:
  - Each valid byte is registered to o_Payload with o_Payload_Valid=1 on the next cycle (1-cycle latency); counter increments.
- DISC:
  - Valid bytes only increment the counter; no outputs.
- End of packet: on the valid byte where counter = PKT_BYTES-1 (PAY or DISC):
  - o_Done pulses on the next cycle, in the same cycle as that final o_Payload_Valid in PAY.
  - Return to IDLE; o_Busy falls in the same cycle o_Done rises.
- Gaps: bytes may arrive with arbitrary idle cycles between them; the counter advances only on i_Byte_Valid.
- i_Start while o_Busy=1 (abort/restart):
  - Current packet is abandoned: no o_Done; no o_Match/o_Drop if still in HDR.
  - Re-latch i_Addr, clear counter and mismatch flag, re-enter HDR.
  - i_Start has priority over a coincident i_Byte_Valid; that byte is dropped.
- i_Start and i_Byte_Valid in the same cycle in IDLE: the byte is ignored; the first header byte is the next valid byte.
- Reset mid-packet: immediate return to IDLE; any pulse in flight is lost.
- Counter width: $clog2(PKT_BYTES); no wrap-around is possible because of the end-of-packet return to IDLE.

Test Plan (ADDR_BYTES=2, PKT_BYTES=6, i_Addr=16'hAB12):
- Match path: i_Start, then bytes AB,12,01,02,03,04 back-to-back -> o_Match one cycle after 12; o_Payload 01..04 with one valid each; o_Done together with 04; o_Drop never asserted.
- Mismatch on the first byte: bytes AA,12,01,02,03,04 -> o_Cmp_Data1=AA, o_Cmp_Data2=AB on the first byte; o_Drop once; no o_Payload_Valid; o_Done once.
- Mismatch on the last header byte: bytes AB,13,... -> o_Drop (not o_Match); payload discarded.
- Gapped input: match packet with 3 idle cycles between every byte -> same outputs as the match path; o_Busy held high throughout.
- Abort: i_Start after AB,12,01, then a full matching packet -> no o_Done for the first packet; second packet forwards 4 bytes and o_Done fires once.
- Async reset: assert i_Rst_n=0 mid-payload -> all outputs 0 immediately; bytes without i_Start after release produce no outputs.

Source files
------------

// File: rtl/rx_addr_filter_if.sv
// Byte-stream, comparator and result signals of rx_addr_filter, bundled for the port list.
// The filter sits on the slave modport; the upstream byte source and sinks use master.
interface rx_addr_filter_if #(
    parameter int ADDR_BYTES = 2
);
    // Handshake: i_Byte is consumed in every cycle where i_Byte_Valid=1. There is
    // no ready/backpressure, and each o_*_Valid or pulse output lasts exactly one cycle.
    logic [8*ADDR_BYTES-1:0] i_Addr;
    logic                    i_Start;
    logic [7:0]              i_Byte;
    logic                    i_Byte_Valid;
    logic [7:0]              o_Cmp_Data1;
    logic [7:0]              o_Cmp_Data2;
    logic                    i_Cmp_Equal;
    logic [7:0]              o_Payload;
    logic                    o_Payload_Valid;
    logic                    o_Match;
    logic                    o_Drop;
    logic                    o_Done;
    logic                    o_Busy;
    logic [1:0]              o_Dbg_State;

    modport slave (
        input  i_Addr, i_Start, i_Byte, i_Byte_Valid, i_Cmp_Equal,
        output o_Cmp_Data1, o_Cmp_Data2, o_Payload, o_Payload_Valid,
               o_Match, o_Drop, o_Done, o_Busy, o_Dbg_State
    );

    modport master (
        output i_Addr, i_Start, i_Byte, i_Byte_Valid, i_Cmp_Equal,
        input  o_Cmp_Data1, o_Cmp_Data2, o_Payload, o_Payload_Valid,
               o_Match, o_Drop, o_Done, o_Busy, o_Dbg_State
    );
endinterface

// File: rtl/rx_addr_filter.sv
// Header address filter for nRF RX packets: walks an external comparator over the
// header bytes, then forwards the payload of matching packets and discards the rest.
module rx_addr_filter #(
    parameter int ADDR_BYTES = 2,
    parameter int PKT_BYTES  = 10
) (
    input  logic            i_Clk,
    input  logic            i_Rst_n,
    rx_addr_filter_if.slave bus
);
    localparam int CNT_W = $clog2(PKT_BYTES);
    localparam logic [CNT_W-1:0] LAST_HDR = CNT_W'(ADDR_BYTES - 1);
    localparam logic [CNT_W-1:0] LAST_PKT = CNT_W'(PKT_BYTES - 1);

    typedef enum logic [1:0] {IDLE, HDR, PAY, DISC} state_t;

    state_t                  state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic                    mis, mis_n, mis_now;
    logic [8*ADDR_BYTES-1:0] addr_q, addr_n;
    logic [7:0]              payload, payload_n;
    logic                    pv, pv_n, match, match_n, drop, drop_n;
    logic                    done, done_n, busy, busy_n;
    logic [7:0]              cmp_data1, cmp_data2;

    // Header byte 0 is the most significant byte of the latched address.
    always_comb begin
        cmp_data1 = 8'h00;
        cmp_data2 = 8'h00;
        if (state == HDR) begin
            cmp_data1 = bus.i_Byte;
            for (int k = 0; k < ADDR_BYTES; k++) begin
                if (cnt == CNT_W'(k)) cmp_data2 = addr_q[8*(ADDR_BYTES-1-k) +: 8];
            end
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        mis_n     = mis;
        addr_n    = addr_q;
        payload_n = payload;
        pv_n      = 1'b0;
        match_n   = 1'b0;
        drop_n    = 1'b0;
        done_n    = 1'b0;
        busy_n    = busy;
        mis_now   = mis | ~bus.i_Cmp_Equal;
        // A start pulse restarts from any state and swallows a coincident byte.
        if (bus.i_Start) begin
            addr_n  = bus.i_Addr;
            cnt_n   = '0;
            mis_n   = 1'b0;
            state_n = HDR;
            busy_n  = 1'b1;
        end else if (bus.i_Byte_Valid) begin
            unique case (state)
                IDLE: ;
                HDR: begin
                    cnt_n = cnt + CNT_W'(1);
                    mis_n = mis_now;
                    if (cnt == LAST_HDR) begin
                        match_n = ~mis_now;
                        drop_n  = mis_now;
                        state_n = mis_now ? DISC : PAY;
                    end
                end
                PAY, DISC: begin
                    cnt_n = cnt + CNT_W'(1);
                    if (state == PAY) begin
                        payload_n = bus.i_Byte;
                        pv_n      = 1'b1;
                    end
                    if (cnt == LAST_PKT) begin
                        done_n  = 1'b1;
                        busy_n  = 1'b0;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mis     <= 1'b0;
            addr_q  <= '0;
            payload <= 8'h00;
            pv      <= 1'b0;
            match   <= 1'b0;
            drop    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            mis     <= mis_n;
            addr_q  <= addr_n;
            payload <= payload_n;
            pv      <= pv_n;
            match   <= match_n;
            drop    <= drop_n;
            done    <= done_n;
            busy    <= busy_n;
        end
    end

    assign bus.o_Cmp_Data1     = cmp_data1;
    assign bus.o_Cmp_Data2     = cmp_data2;
    assign bus.o_Payload       = payload;
    assign bus.o_Payload_Valid = pv;
    assign bus.o_Match         = match;
    assign bus.o_Drop          = drop;
    assign bus.o_Done          = done;
    assign bus.o_Busy          = busy;
    assign bus.o_Dbg_State     = state;
endmodule
